fp_div_out_stage: RTL and testbench

Registered output stage placed directly downstream of the combinational `fp_div` divider. It captures each quotient and its exception flags (`exp_overflow`, `nan`, `zero`) through a valid/ready handshake. It canonicalises special results, buffers them in a small FIFO, and releases them to the consumer. It also keeps sticky exception flags and saturating event counters for software or status logic.

---
 rtl/fp_div_out_stage.sv | 114 +++++++++++
 tb/tb_fp_div_out_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_out_stage.sv
// fp_div_out_stage: registered output FIFO behind the fp_div divider.
// Canonicalises special results and tracks sticky flags and event counters.
module fp_div_out_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_res,
  input  logic             in_exp_overflow,
  input  logic             in_nan,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [2:0]       out_flags,
  output logic [2:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] nan_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem_res [DEPTH];
  logic [2:0]    mem_flg [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          push;
  logic          pop;
  logic [31:0]   canon;
  logic [2:0]    in_flags;

  assign in_ready  = (occ != FULL_CNT);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_flags  = {in_exp_overflow, in_nan, in_zero};
  assign out_res   = mem_res[rd_ptr];
  assign out_flags = mem_flg[rd_ptr];

  // Canonicalise specials: nan beats overflow beats zero.
  always_comb begin
    canon = in_res;
    if (in_nan)
      canon = 32'h7FC0_0000;
    else if (in_exp_overflow)
      canon = {in_res[31], 8'hFF, 23'h0};
    else if (in_zero)
      canon = {in_res[31], 31'h0};
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_res[i] <= '0;
        mem_flg[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem_res[wr_ptr] <= canon;
        mem_flg[wr_ptr] <= in_flags;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky flags: set on push wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_flags <= '0;
    else if (sticky_clr)
      sticky_flags <= push ? in_flags : 3'b000;
    else if (push)
      sticky_flags <= sticky_flags | in_flags;
  end

  // Saturating overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_cnt <= '0;
    else if (sticky_clr)
      ovf_cnt <= (push && in_exp_overflow) ? CNT_W'(1) : '0;
    else if (push && in_exp_overflow && (ovf_cnt != '1))
      ovf_cnt <= ovf_cnt + CNT_W'(1);
  end

  // Saturating nan counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nan_cnt <= '0;
    else if (sticky_clr)
      nan_cnt <= (push && in_nan) ? CNT_W'(1) : '0;
    else if (push && in_nan && (nan_cnt != '1))
      nan_cnt <= nan_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fp_div_out_stage.sv
// tb_fp_div_out_stage: directed vectors plus hand-written sequences
// for backpressure, streaming, counters, saturation and async reset.
module tb_fp_div_out_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_res;
  logic             in_exp_overflow;
  logic             in_nan;
  logic             in_zero;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [2:0]       out_flags;
  logic [2:0]       sticky_flags;
  logic             sticky_clr;
  logic [CNT_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] nan_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fp_div_out_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_res          (in_res),
    .in_exp_overflow (in_exp_overflow),
    .in_nan          (in_nan),
    .in_zero         (in_zero),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_res         (out_res),
    .out_flags       (out_flags),
    .sticky_flags    (sticky_flags),
    .sticky_clr      (sticky_clr),
    .ovf_cnt         (ovf_cnt),
    .nan_cnt         (nan_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        nan;
    logic        zero;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] r,
                       input logic o, input logic n, input logic z);
    in_valid        = v;
    in_res          = r;
    in_exp_overflow = o;
    in_nan          = n;
    in_zero         = z;
  endtask

  initial begin
    vecs[0] = '{32'h40490FDB, 1'b0, 1'b0, 1'b0, 32'h40490FDB};
    vecs[1] = '{32'h12345678, 1'b0, 1'b1, 1'b0, 32'h7FC00000};
    vecs[2] = '{32'h80001234, 1'b1, 1'b0, 1'b0, 32'hFF800000};
    vecs[3] = '{32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000};
    vecs[4] = '{32'hABCDEF01, 1'b0, 1'b1, 1'b1, 32'h7FC00000};

    rst_n      = 1'b0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_res", out_res, 32'h0);
    chk("rst out_flags", 32'(out_flags), 32'd0);
    chk("rst sticky", 32'(sticky_flags), 32'd0);
    chk("rst ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst nan_cnt", 32'(nan_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single push and canonicalisation vectors
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].res, vecs[i].ovf, vecs[i].nan, vecs[i].zero);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d out_res", i), out_res, vecs[i].exp_res);
      chk($sformatf("vec%0d out_flags", i), 32'(out_flags),
          32'({vecs[i].ovf, vecs[i].nan, vecs[i].zero}));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: fill with A, B; C must wait
    drive(1'b1, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hBBBB0002, 1'b0, 1'b0, 1'b0);
    step();
    chk("full in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hCCCC0003, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("full hold in_ready", 32'(in_ready), 32'd0);
    chk("full head stable", out_res, 32'hAAAA0001);
    out_ready = 1'b1;
    step();
    chk("bp second", out_res, 32'hBBBB0002);
    chk("bp in_ready back", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bp third", out_res, 32'hCCCC0003);
    chk("bp third valid", 32'(out_valid), 32'd1);
    step();
    chk("bp empty", 32'(out_valid), 32'd0);

    // Streaming with wrap-around
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("stream%0d res", i), out_res, 32'(i));
      chk($sformatf("stream%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("stream end", 32'(out_valid), 32'd0);

    // Sticky flags and counters
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("clr sticky", 32'(sticky_flags), 32'd0);
    chk("clr nan_cnt", 32'(nan_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h3F800000, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("cnt ovf", 32'(ovf_cnt), 32'd3);
    chk("cnt nan", 32'(nan_cnt), 32'd1);
    chk("cnt sticky", 32'(sticky_flags), 32'b110);
    step();
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("clrset sticky", 32'(sticky_flags), 32'b010);
    chk("clrset nan", 32'(nan_cnt), 32'd1);
    chk("clrset ovf", 32'(ovf_cnt), 32'd0);
    step();

    // Saturation at CNT_W=2
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat ovf", 32'(ovf_cnt), 32'd3);
    chk("sat sticky", 32'(sticky_flags), 32'b110);
    step();

    // Async reset mid-cycle with two entries held
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre-rst full", 32'(in_ready), 32'd0);
    chk("pre-rst valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst in_ready", 32'(in_ready), 32'd1);
    chk("arst out_res", out_res, 32'h0);
    chk("arst ovf_cnt", 32'(ovf_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post-rst valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
